update_field: RTL and testbench
===============================

# update_field

Pattern generator for the fluid-simulation vector field. On a `start` pulse it sweeps every cell of a FIELD_WIDTH × FIELD_HEIGHT field and writes one 96-bit vector word per clock into the field RAM's write port. Each word holds a unit direction (xn, yn) and a magnitude. An internal phase counter advances once per pass, so the direction pattern rotates from frame to frame. It sits between the simulation controller (which drives `start` and waits for `done`) and the field memory.

## Interface
Parameters:
- FIELD_WIDTH, 8, cells per row (x extent).
- FIELD_HEIGHT, 6, number of rows (y extent).
- FIELD_DATAW, 96, field word width. Must be 96: three 32-bit signed Q16.16 lanes.
- FIELD_ADDRW (derived localparam), $clog2(FIELD_WIDTH*FIELD_HEIGHT).

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a pass when the block is idle.
- done  out  1  one-cycle pulse after the last write of a pass.
- field_data_in  out  FIELD_DATAW  write data to the field RAM: {xn[95:64], yn[63:32], mag[31:0]}.
- field_addr_write  out  FIELD_ADDRW  write address, row-major: y*FIELD_WIDTH + x.
- field_we  out  1  write enable, one word per cycle.

## Operation
- FSM states: IDLE → WRITE → DONE → IDLE.
- IDLE: `start`=1 at a clock edge → WRITE, with x=0, y=0.
- WRITE:
  - One cell per cycle. x increments fastest; on x=FIELD_WIDTH-1, x wraps to 0 and y increments.
  - After cell (FIELD_WIDTH-1, FIELD_HEIGHT-1) → DONE.
- DONE: lasts one cycle, then → IDLE. `phase` (3-bit) increments mod 8 on the DONE→IDLE transition.
- `start` is ignored in WRITE and DONE; there is no queuing.
- Per-cell outputs, driven combinationally from state and counters while in WRITE:
  - dx = 2x − (FIELD_WIDTH−1), dy = 2y − (FIELD_HEIGHT−1), both signed.
  - mag = (|dx|+|dy|) << 15. This is the Manhattan distance from the field centre in cell units, Q16.16.
  - d = (x + y + phase) mod 8.
  - (xn, yn) for d = 0..7: (1,0), (c,c), (0,1), (−c,c), (−1,0), (−c,−c), (0,−1), (c,−c).
  - 1.0 = 0x00010000, −1.0 = 0xFFFF0000, c = 0x0000B505, −c = 0xFFFF4AFB.
  - Negative values are two's complement, 32 bits per lane.
- Outside WRITE: field_we=0; field_addr_write and field_data_in are 0.

## Timing
- Reset (reset=0, asynchronous):
  - State returns to IDLE; x, y and phase are cleared to 0.
  - done=0 and field_we=0; address and data outputs are 0.
  - Takes effect immediately, including mid-pass. The aborted pass produces no `done` and does not advance `phase`.
- `start` sampled high at edge E0 in IDLE:
  - Write cycles occupy the cycles following E0 through E48 (for 8×6). Each write commits at the closing edge of its cycle.
  - field_we is high for exactly FIELD_SIZE consecutive cycles, with addresses 0..FIELD_SIZE−1, with no gaps or repeats.
  - done=1 for exactly one cycle, immediately after the last write cycle, with field_we=0 in that cycle.
  - Next `start` accepted: from the cycle after done, i.e. IDLE.
  - Minimum `start`-to-`done` latency: FIELD_SIZE+1 cycles.
- `start` held high continuously: a new pass begins every FIELD_SIZE+2 cycles.
- Phase wraps 7→0 after the 8th completed pass.

## Test plan
- Reset → all outputs 0. `start` during reset is ignored. After release, no write occurs until `start`.
- First pass (phase 0):
  - addr 0: xn=0x00010000, yn=0, mag=0x00060000.
  - addr 19 (x=3, y=2): xn=yn=0xFFFF4AFB, mag=0x00010000.
  - addr 47: xn=0xFFFF0000, yn=0, mag=0x00060000.
  - field_we high for exactly 48 cycles; done pulses once, 49 cycles after the start edge.
- Second pass: addr 0 has xn=yn=0x0000B505. After 8 completed passes, addr 0 is again xn=0x00010000, yn=0.
- `start` pulsed at write cycle 10 and during DONE → ignored. Still exactly 48 writes and one done pulse, and phase advances by 1 only.
- Assert reset at write cycle 20 → field_we drops at once and no done pulse occurs. A new `start` restarts from addr 0 with phase 0.
- 100 back-to-back start/wait-for-done iterations → every pass writes addresses 0..47 in order, and done never pulses twice per pass.

Source files
------------

// File: rtl/update_field.sv
// update_field: sweeps the fluid field once per start pulse, writing a rotating
// unit-direction vector and centre-distance magnitude into every cell.
module update_field #(
    parameter int FIELD_WIDTH  = 8,
    parameter int FIELD_HEIGHT = 6,
    parameter int FIELD_DATAW  = 96,
    localparam int FIELD_ADDRW = $clog2(FIELD_WIDTH * FIELD_HEIGHT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   done,
    output logic [FIELD_DATAW-1:0] field_data_in,
    output logic [FIELD_ADDRW-1:0] field_addr_write,
    output logic                   field_we
);
    localparam int XW = FIELD_WIDTH > 1 ? $clog2(FIELD_WIDTH) : 1;
    localparam int YW = FIELD_HEIGHT > 1 ? $clog2(FIELD_HEIGHT) : 1;
    localparam logic [31:0] ONE = 32'h0001_0000;
    localparam logic [31:0] C   = 32'h0000_B505;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [2:0]      phase_q, phase_d;
    logic            last_x, last_y;
    int              dx, dy;
    logic [2:0]      d;
    logic [31:0]     xn, yn, mag;

    // Cosine of the d*45 degree direction; sine is the same table shifted by 90 degrees.
    function automatic logic [31:0] cos_lane(input logic [2:0] k);
        return k == 3'd0 ? ONE :
               (k == 3'd1 || k == 3'd7) ? C :
               (k == 3'd2 || k == 3'd6) ? 32'd0 :
               (k == 3'd3 || k == 3'd5) ? -C : -ONE;
    endfunction

    assign last_x = x_q == XW'(FIELD_WIDTH - 1);
    assign last_y = y_q == YW'(FIELD_HEIGHT - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = WRITE;
                x_d     = '0;
                y_d     = '0;
            end
            WRITE: begin
                x_d = last_x ? '0 : x_q + 1'b1;
                y_d = last_x ? (last_y ? '0 : y_q + 1'b1) : y_q;
                if (last_x && last_y) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                phase_d = phase_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dx               = 2 * int'(x_q) - (FIELD_WIDTH - 1);
        dy               = 2 * int'(y_q) - (FIELD_HEIGHT - 1);
        mag              = 32'(((dx < 0 ? -dx : dx) + (dy < 0 ? -dy : dy)) << 15);
        d                = 3'(int'(x_q) + int'(y_q) + int'(phase_q));
        xn               = cos_lane(d);
        yn               = cos_lane(d - 3'd2);
        field_we         = state_q == WRITE;
        done             = state_q == DONE;
        field_addr_write = field_we ? FIELD_ADDRW'(int'(y_q) * FIELD_WIDTH + int'(x_q)) : '0;
        field_data_in    = field_we ? {xn, yn, mag} : '0;
    end
endmodule

// File: tb/tb_update_field.sv
// tb_update_field: vector table plus randomized passes against a cell-level model.
module tb_update_field;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int FS = W * H;
    localparam int AW = $clog2(FS);

    logic          clk = 0;
    logic          reset = 0;
    logic          start = 0;
    logic          done;
    logic [95:0]   data;
    logic [AW-1:0] addr;
    logic          we;

    int tests = 0;
    int fails = 0;
    int ph_m = 0;
    int pass_cnt = 0;
    logic [95:0] cap [FS];

    typedef struct {
        int          pass_no;
        int          addr;
        logic [95:0] exp;
    } vec_t;
    vec_t tbl [5];

    update_field #(.FIELD_WIDTH(W), .FIELD_HEIGHT(H), .FIELD_DATAW(96)) dut (
        .clk(clk), .reset(reset), .start(start), .done(done),
        .field_data_in(data), .field_addr_write(addr), .field_we(we)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Direction index k*45deg; 2 -> 1.0, 1 -> c, 0 -> 0, negatives mirrored.
    function automatic logic [31:0] lane(input int s);
        case (s)
            2:       return 32'h0001_0000;
            1:       return 32'h0000_B505;
            0:       return 32'h0;
            -1:      return 32'hFFFF_4AFB;
            default: return 32'hFFFF_0000;
        endcase
    endfunction

    function automatic logic [95:0] model(input int a, input int ph);
        int cs [8] = '{2, 1, 0, -1, -2, -1, 0, 1};
        int x = a % W;
        int y = a / W;
        int ax = 2 * x - (W - 1);
        int ay = 2 * y - (H - 1);
        int m = (ax < 0 ? -ax : ax) + (ay < 0 ? -ay : ay);
        int dd = (x + y + ph) % 8;
        return {lane(cs[dd]), lane(cs[(dd + 6) % 8]), 32'(m * 32768)};
    endfunction

    // Starts one pass at the current negedge and follows it to the idle cycle after done.
    task automatic run_pass(input int pulse_at, input bit pulse_done, input int abort_at);
        int nw = 0;
        int nd = 0;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        for (int cyc = 1; cyc <= FS + 2; cyc++) begin
            @(negedge clk);
            if (cyc == abort_at) begin
                reset = 0;
                #1;
                check("abort_we", 96'(we), 96'(0));
                check("abort_done", 96'(done), 96'(0));
                check("abort_addr", 96'(addr), 96'(0));
                start = 1;
                repeat (2) @(negedge clk);
                start = 0;
                reset = 1;
                repeat (3) begin
                    @(negedge clk);
                    check("post_abort_we", 96'(we), 96'(0));
                    check("post_abort_done", 96'(done), 96'(0));
                end
                ph_m = 0;
                pass_cnt = 0;
                return;
            end
            if (we) begin
                check("addr_order", 96'(addr), 96'(nw));
                check("write_data", data, model(nw, ph_m));
                if (nw < FS) cap[nw] = data;
                nw++;
            end
            if (done) begin
                nd++;
                check("done_latency", 96'(cyc), 96'(FS + 1));
                check("done_we_low", 96'(we), 96'(0));
            end
            start = (cyc == pulse_at) || (pulse_done && cyc == FS + 1);
        end
        start = 0;
        check("write_count", 96'(nw), 96'(FS));
        check("done_count", 96'(nd), 96'(1));
        for (int i = 0; i < 5; i++)
            if (tbl[i].pass_no == pass_cnt)
                check($sformatf("vec%0d_addr%0d", i, tbl[i].addr), cap[tbl[i].addr], tbl[i].exp);
        ph_m = (ph_m + 1) % 8;
        pass_cnt++;
    endtask

    initial begin
        int t1, found, gap, pa;
        bit pd;
        tbl[0] = '{0, 0,  {32'h0001_0000, 32'h0,          32'h0006_0000}};
        tbl[1] = '{0, 19, {32'hFFFF_4AFB, 32'hFFFF_4AFB,  32'h0001_0000}};
        tbl[2] = '{0, 47, {32'hFFFF_0000, 32'h0,          32'h0006_0000}};
        tbl[3] = '{1, 0,  {32'h0000_B505, 32'h0000_B505,  32'h0006_0000}};
        tbl[4] = '{8, 0,  {32'h0001_0000, 32'h0,          32'h0006_0000}};

        start = 1;
        repeat (3) @(negedge clk);
        check("rst_we", 96'(we), 96'(0));
        check("rst_done", 96'(done), 96'(0));
        check("rst_addr", 96'(addr), 96'(0));
        check("rst_data", data, 96'(0));
        start = 0;
        reset = 1;
        repeat (5) begin
            @(negedge clk);
            check("idle_no_write", 96'(we), 96'(0));
        end

        for (int p = 0; p <= 8; p++) run_pass(p == 2 ? 11 : 0, p == 2, 0);

        run_pass(0, 0, 21);
        run_pass(0, 0, 0);

        start = 1;
        t1 = 0;
        found = 0;
        for (int c = 0; c < 200 && found < 2; c++) begin
            @(negedge clk);
            if (done) begin
                if (found == 0) t1 = c;
                else begin
                    check("held_period", 96'(c - t1), 96'(FS + 2));
                    start = 0;
                end
                found++;
            end
        end
        start = 0;
        check("held_dones", 96'(found), 96'(2));
        ph_m = (ph_m + 2) % 8;
        pass_cnt += 2;
        @(negedge clk);

        for (int i = 0; i < 100; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            pa = $urandom_range(0, 1) ? $urandom_range(1, FS + 1) : 0;
            pd = 1'($urandom_range(0, 1));
            run_pass(pa, pd, (i % 25 == 24) ? $urandom_range(2, FS) : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
